// File: rtl/acpi_out_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | acpi_out_pkg                                                         |
// | Shared widths, FIFO entry layout, FSM states and pixel conversion.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package acpi_out_pkg;

    localparam int N_PIX_DEFAULT = 16384;
    localparam int ADDR_W        = 14;
    localparam int DATA_W        = 14;
    localparam int BYTE_W        = 8;
    localparam int CNT_W         = 15;
    localparam int CHK_W         = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BYTE_W-1:0] data;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Signed 12.2 fixed point -> rounded, clipped unsigned byte.
    function automatic logic [BYTE_W-1:0] acpi_to_byte(input logic [DATA_W-1:0] raw);
        logic signed [DATA_W:0] rounded;
        logic signed [DATA_W:0] shifted;
        rounded = $signed({raw[DATA_W-1], raw}) + $signed((DATA_W+1)'(2));
        shifted = rounded >>> 2;
        if (shifted[DATA_W]) begin
            return '0;
        end else if (shifted[DATA_W-1:BYTE_W] != '0) begin
            return '1;
        end else begin
            return shifted[BYTE_W-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/acpi_out_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | acpi_out_fifo                                                        |
// | Synchronous show-ahead FIFO; push/pop must be pre-qualified.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module acpi_out_fifo
    import acpi_out_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fifo_entry_t push_entry,
    input  logic        pop,
    output fifo_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    fifo_entry_t    mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry;
        end
    end

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {PTR_W{1'b0}}});
    assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule
`default_nettype wire

// File: rtl/acpi_out_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | acpi_out_stream                                                      |
// | Converts ACPI green pixels to bytes and streams them downstream.     |
// | Optional checksum accumulator enabled by ACPI_OUT_CHKSUM_EN.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module acpi_out_stream
    import acpi_out_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int N_PIX      = N_PIX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acpi_valid_1,
    input  logic [ADDR_W-1:0] acpi_addr,
    input  logic [DATA_W-1:0] acpi_data,
    input  logic              finish,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [BYTE_W-1:0] out_data,
    output logic              done,
    output logic              overflow,
    output logic              count_err,
    output logic [CHK_W-1:0]  chksum
);

    localparam logic [CNT_W-1:0] N_PIX_C = CNT_W'(N_PIX);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic              overflow_q, overflow_d;
    logic              count_err_q, count_err_d;
    logic              push, pop, full, empty;
    fifo_entry_t       push_entry, head;

    assign push_entry.addr = acpi_addr;
    assign push_entry.data = acpi_to_byte(acpi_data);
    assign pop             = !empty && out_ready;

    acpi_out_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty)
    );

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        overflow_d  = overflow_q;
        count_err_d = count_err_q;
        push        = 1'b0;

        // A full FIFO still accepts when the same edge frees a slot.
        if (acpi_valid_1 && (state_q != ST_DONE)) begin
            if (pix_cnt_q >= N_PIX_C) begin
                count_err_d = 1'b1;
            end else if (full && !pop) begin
                overflow_d = 1'b1;
            end else begin
                push      = 1'b1;
                pix_cnt_d = pix_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (finish) begin
                    state_d = ST_DRAIN;
                end else if (acpi_valid_1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (finish) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (empty && !push) begin
                    state_d = ST_DONE;
                    if (pix_cnt_q != N_PIX_C) begin
                        count_err_d = 1'b1;
                    end
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pix_cnt_q   <= '0;
            overflow_q  <= 1'b0;
            count_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            overflow_q  <= overflow_d;
            count_err_q <= count_err_d;
        end
    end

    assign out_valid = !empty;
    assign out_addr  = empty ? '0 : head.addr;
    assign out_data  = empty ? '0 : head.data;
    assign done      = (state_q == ST_DONE);
    assign overflow  = overflow_q;
    assign count_err = count_err_q;

`ifdef ACPI_OUT_CHKSUM_EN
    logic [CHK_W-1:0] chksum_q, chksum_d;

    always_comb begin
        chksum_d = chksum_q;
        if (pop) begin
            chksum_d = chksum_q + CHK_W'(out_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chksum_q <= '0;
        end else begin
            chksum_q <= chksum_d;
        end
    end

    assign chksum = chksum_q;
`else
    assign chksum = '0;
`endif

endmodule
`default_nettype wire

// File: doc/acpi_out_stream.md
ACPI_OUT_STREAM -- requirements
Module: acpi_out_stream

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, power of two, minimum 4, output FIFO entries.
REQ-002 SHALL have parameter N_PIX, default 16384, green-plane pixel count (128x128).
REQ-003 SHALL have port clk, input, 1 bit, single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port acpi_valid_1, input, 1 bit, green-pixel write strobe from ACPI.
REQ-006 SHALL have port acpi_addr, input, 14 bits, pixel index 0..16383.
REQ-007 SHALL have port acpi_data, input, 14 bits, signed 12.2 fixed-point green value.
REQ-008 SHALL have port finish, input, 1 bit, ACPI end-of-frame indication.
REQ-009 SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit), out_addr (output, 14 bits), out_data (output, 8 bits): the downstream stream.
REQ-010 SHALL have ports done (output, 1 bit), overflow (output, 1 bit, sticky), count_err (output, 1 bit), chksum (output, 16 bits).

Function
REQ-011 SHALL convert acpi_data: add 2, arithmetic shift right 2, clip to 0..255 (negative -> 0x00, >255 -> 0xFF).
REQ-012 SHALL push {acpi_addr, converted byte} into the FIFO on the edge where acpi_valid_1=1; out_valid SHALL be high from the next cycle (1-cycle latency, show-ahead).
REQ-013 SHALL pop one entry on each edge where out_valid=1 and out_ready=1; out_addr/out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-014 SHALL accept a push when full if a pop occurs on the same edge; otherwise a push when full SHALL be dropped and SHALL set overflow (sticky until rst).
REQ-015 SHALL allow simultaneous push and pop with unchanged occupancy; on empty, pushed data SHALL NOT bypass to the output in the same cycle.
REQ-016 SHALL count accepted pushes in a 15-bit counter pix_cnt; pushes after pix_cnt reaches N_PIX SHALL be dropped and SHALL set count_err.
REQ-017 SHALL implement FSM IDLE -> RUN on first acpi_valid_1; RUN -> DRAIN on finish=1; DRAIN -> DONE when the FIFO is empty; DONE holds until rst.
REQ-018 SHALL accept pushes in IDLE (the push that triggers IDLE->RUN), RUN and DRAIN, and ignore acpi_valid_1 in DONE.
REQ-019 SHALL assert done=1 in DONE only; on entering DONE, count_err SHALL be set if pix_cnt != N_PIX.
REQ-020 SHALL, if finish=1 arrives while in IDLE, go IDLE -> DRAIN -> DONE with count_err=1.

Reset
REQ-021 SHALL, on rst=1 at a clock edge, clear FIFO pointers, pix_cnt and chksum, set state IDLE, and drive out_valid=0, out_addr=0, out_data=0, done=0, overflow=0, count_err=0, chksum=0.
REQ-022 SHALL discard all buffered entries on reset mid-frame, with no out_valid pulse in the cycle after reset.

Configuration
REQ-023 SHALL, with ACPI_OUT_CHKSUM_EN defined, accumulate chksum = chksum + out_data (mod 2^16) on each pop.
REQ-024 SHALL, without ACPI_OUT_CHKSUM_EN, keep the chksum port present and tied to 0, with no accumulator logic.

Structure
REQ-025 SHALL place N_PIX default, data/address widths, FIFO entry struct and FSM state enum in package acpi_out_pkg.
REQ-026 SHALL implement the buffer as sub-module acpi_out_fifo (synchronous, show-ahead, full/empty, FIFO_DEPTH entries).

Verification
REQ-027 Rounding: acpi_data=14'h0206 at addr 5 -> out_data=0x82, out_addr=5 one cycle later.
REQ-028 Clipping: 14'h3FF0 -> 0x00; 14'h1FFF -> 0xFF; 14'h03FE -> 0xFF; 14'h0001 -> 0x00.
REQ-029 Backpressure: out_ready=0, 12 consecutive pushes, FIFO_DEPTH=8 -> overflow=1, exactly 8 entries (pushes 1-8) popped in order once out_ready=1.
REQ-030 Full-with-pop: FIFO full, push and pop on the same edge -> no overflow, occupancy stays 8.
REQ-031 Full frame: 16384 pushes at addr 0..16383, random out_ready, then finish -> done=1 after drain, count_err=0; with ACPI_OUT_CHKSUM_EN, chksum equals the model sum mod 65536.
REQ-032 Reset mid-frame: rst after 100 pushes -> all outputs 0, state IDLE, the next frame completes with count_err=0.
